vga_pixel_gen: RTL and testbench

- Pixel-generation stage directly downstream of the VGA sync/timing generator.
- Consumes the timing generator's x, y, video_on, hsync and vsync, and reads a low-resolution RGB332 framebuffer from an external synchronous RAM.
- Expands each framebuffer pixel to RGB444, overlays a blinking rectangular cursor, and emits RGB plus sync, all delayed through a matched 2-cycle pipeline.

---
 rtl/vga_pixel_gen.sv | 158 +++++++++++++++
 tb/tb_vga_pixel_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_gen.sv
// VGA pixel-generation stage: RGB332 framebuffer fetch, RGB444 expansion,
// double-buffered blinking cursor overlay, sync delay matched to a 2-cycle pipe.
module vga_pixel_gen #(
    parameter int unsigned FB_W      = 160,
    parameter int unsigned FB_H      = 120,
    parameter int unsigned SCALE_SH  = 2,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned CUR_SIZE  = 16,
    parameter logic [11:0] CUR_COLOR = 12'hFFF,
    parameter int unsigned BLINK_BIT = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_en,
    input  logic [7:0]        fb_rdata,
    input  logic [9:0]        cur_x,
    input  logic [9:0]        cur_y,
    input  logic              cur_en,
    input  logic              cur_wr,
    output logic [11:0]       rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic [5:0]        frame_cnt
);

    // Headroom so coordinates beyond the visible area never overflow before truncation
    localparam int unsigned SUM_W = $clog2(FB_W * FB_H) + 2 * SCALE_SH + 2;
    localparam int unsigned CRD_W = 11;

    logic [SUM_W-1:0] w_row;
    logic [SUM_W-1:0] w_col;
    logic [SUM_W-1:0] w_lin;
    logic [CRD_W-1:0] w_x;
    logic [CRD_W-1:0] w_y;
    logic [CRD_W-1:0] w_ax;
    logic [CRD_W-1:0] w_ay;
    logic             w_hit;
    logic             w_vs_rise;
    logic             w_cur_vis;
    logic [11:0]      w_fb_rgb;
    logic [11:0]      w_rgb_nxt;

    logic             r_von_d1;
    logic             r_hs_d1;
    logic             r_vs_d1;
    logic             r_hit_d1;
    logic [11:0]      r_rgb;
    logic             r_hs_d2;
    logic             r_vs_d2;
    logic             r_frame_start;
    logic [5:0]       r_frame_cnt;
    logic [9:0]       r_shd_x;
    logic [9:0]       r_shd_y;
    logic             r_shd_en;
    logic [9:0]       r_act_x;
    logic [9:0]       r_act_y;
    logic             r_act_en;

    // Stage 0: framebuffer address from the down-scaled screen position
    always_comb begin
        w_row = SUM_W'(y >> SCALE_SH);
        w_col = SUM_W'(x >> SCALE_SH);
        w_lin = w_row * SUM_W'(FB_W) + w_col;
    end

    assign fb_addr = video_on ? ADDR_W'(w_lin) : '0;
    assign fb_en   = video_on;

    // 11-bit compare keeps a cursor near column/row 1023 from wrapping
    always_comb begin
        w_x   = {1'b0, x};
        w_y   = {1'b0, y};
        w_ax  = {1'b0, r_act_x};
        w_ay  = {1'b0, r_act_y};
        w_hit = (w_x >= w_ax) && (w_x < w_ax + CRD_W'(CUR_SIZE)) &&
                (w_y >= w_ay) && (w_y < w_ay + CRD_W'(CUR_SIZE));
    end

    // r_vs_d1 doubles as the vsync edge-detect delay
    assign w_vs_rise = vsync_in & ~r_vs_d1;

    assign w_fb_rgb  = {fb_rdata[7:5], fb_rdata[7],
                        fb_rdata[4:2], fb_rdata[4],
                        fb_rdata[1:0], fb_rdata[1:0]};
    assign w_cur_vis = r_hit_d1 & r_act_en & ~r_frame_cnt[BLINK_BIT];

    always_comb begin
        w_rgb_nxt = 12'h000;
        if (r_von_d1) begin
            w_rgb_nxt = w_cur_vis ? CUR_COLOR : w_fb_rgb;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_von_d1 <= 1'b0;
            r_hs_d1  <= 1'b0;
            r_vs_d1  <= 1'b0;
            r_hit_d1 <= 1'b0;
            r_rgb    <= 12'h000;
            r_hs_d2  <= 1'b0;
            r_vs_d2  <= 1'b0;
        end else begin
            r_von_d1 <= video_on;
            r_hs_d1  <= hsync_in;
            r_vs_d1  <= vsync_in;
            r_hit_d1 <= w_hit;
            r_rgb    <= w_rgb_nxt;
            r_hs_d2  <= r_hs_d1;
            r_vs_d2  <= r_vs_d1;
        end
    end

    // Frame boundary: pulse, count, and promote the shadow cursor to active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 6'd0;
            r_act_x       <= 10'd0;
            r_act_y       <= 10'd0;
            r_act_en      <= 1'b0;
        end else begin
            r_frame_start <= w_vs_rise;
            if (w_vs_rise) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
                r_act_x     <= r_shd_x;
                r_act_y     <= r_shd_y;
                r_act_en    <= r_shd_en;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shd_x  <= 10'd0;
            r_shd_y  <= 10'd0;
            r_shd_en <= 1'b0;
        end else if (cur_wr) begin
            r_shd_x  <= cur_x;
            r_shd_y  <= cur_y;
            r_shd_en <= cur_en;
        end
    end

    assign rgb         = r_rgb;
    assign hsync       = r_hs_d2;
    assign vsync       = r_vs_d2;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: vector tables for the pipeline plus
// hand-written cursor, frame-counter and async-reset sequences.
module tb_vga_pixel_gen;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        von;
        logic        hs;
        logic        vs;
        logic [14:0] addr;
        logic [11:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  x, y, cur_x, cur_y;
    logic        video_on, hsync_in, vsync_in, cur_en, cur_wr;
    logic [14:0] fb_addr;
    logic        fb_en;
    logic [7:0]  fb_rdata;
    logic [11:0] rgb;
    logic        hsync, vsync, frame_start;
    logic [5:0]  frame_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [5:0]  exp_fcnt = 6'd0;
    vec_t        tbl[$];

    vga_pixel_gen dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .fb_addr(fb_addr), .fb_en(fb_en),
        .fb_rdata(fb_rdata), .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en),
        .cur_wr(cur_wr), .rgb(rgb), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: address 0/1 hold fixed colours, elsewhere the low address byte
    function automatic logic [7:0] ram_byte(input logic [14:0] a);
        if (a == 15'd0) return 8'hE0;
        if (a == 15'd1) return 8'h1F;
        return a[7:0];
    endfunction

    always @(posedge clk) fb_rdata <= ram_byte(fb_addr);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int vx, input int vy, input bit von, input bit hs,
                       input bit vs, input int addr, input logic [11:0] c);
        vec_t v;
        v.x = 10'(vx); v.y = 10'(vy); v.von = von; v.hs = hs; v.vs = vs;
        v.addr = 15'(addr); v.rgb = c;
        tbl.push_back(v);
    endtask

    // Address checked immediately, rgb/hsync/vsync checked two cycles later
    task automatic run_table();
        int n;
        n = tbl.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                x = tbl[i].x; y = tbl[i].y; video_on = tbl[i].von;
                hsync_in = tbl[i].hs; vsync_in = tbl[i].vs;
            end else begin
                x = 10'd0; y = 10'd0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
            end
            #1;
            if (i < n) begin
                check("fb_addr", 32'(fb_addr), 32'(tbl[i].addr));
                check("fb_en", 32'(fb_en), 32'(tbl[i].von));
            end
            if (i >= 2) begin
                check("rgb", 32'(rgb), 32'(tbl[i-2].rgb));
                check("hsync", 32'(hsync), 32'(tbl[i-2].hs));
                check("vsync", 32'(vsync), 32'(tbl[i-2].vs));
            end
            tick();
        end
    endtask

    task automatic pixel(input string name, input int px, input int py, input logic [11:0] c);
        x = 10'(px); y = 10'(py); video_on = 1'b1;
        tick();
        tick();
        check(name, 32'(rgb), 32'(c));
    endtask

    task automatic vs_pulse(input bit wr);
        if (wr) begin
            cur_x = 10'd300; cur_y = 10'd200; cur_en = 1'b1; cur_wr = 1'b1;
        end
        vsync_in = 1'b1;
        tick();
        cur_wr   = 1'b0;
        exp_fcnt = 6'(exp_fcnt + 6'd1);
        check("frame_start_hi", 32'(frame_start), 32'd1);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        vsync_in = 1'b0;
        tick();
        check("frame_start_lo", 32'(frame_start), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; x = '0; y = '0; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0;
        cur_x = '0; cur_y = '0; cur_en = 1'b0; cur_wr = 1'b0;
        tick(); tick(); tick();
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        reset_n = 1'b1;

        // Framebuffer sweep, address corners and blanking
        tbl.delete();
        add(0, 0, 1, 1, 0, 0, 12'hF00);
        add(1, 0, 1, 1, 0, 0, 12'hF00);
        add(2, 0, 1, 0, 0, 0, 12'hF00);
        add(3, 0, 1, 0, 0, 0, 12'hF00);
        add(4, 0, 1, 1, 0, 1, 12'h0FF);
        add(5, 0, 1, 0, 0, 1, 12'h0FF);
        add(6, 0, 1, 1, 0, 1, 12'h0FF);
        add(7, 0, 1, 0, 0, 1, 12'h0FF);
        add(4, 4, 1, 0, 0, 161, 12'hB05);
        add(639, 479, 1, 1, 0, 19199, 12'hFFF);
        add(639, 479, 0, 0, 0, 0, 12'h000);
        add(100, 20, 0, 1, 0, 0, 12'h000);
        run_table();

        // Mid-frame cursor write stays invisible until the next frame
        cur_x = 10'd100; cur_y = 10'd50; cur_en = 1'b1; cur_wr = 1'b1;
        tick();
        cur_wr = 1'b0;
        pixel("cur_hidden_midframe", 100, 50, 12'h9D5);
        vs_pulse(1'b0);
        pixel("cur_top_left", 100, 50, 12'hFFF);
        pixel("cur_bot_right", 115, 65, 12'hFFF);
        pixel("cur_right_edge", 116, 50, 12'h9F5);
        pixel("cur_left_edge", 99, 50, 12'h9D0);
        pixel("cur_bot_edge", 100, 66, 12'h0D5);

        // Write coinciding with the frame edge: old shadow becomes active
        vs_pulse(1'b1);
        pixel("coinc_new_hidden", 300, 200, 12'h94F);
        pixel("coinc_old_visible", 100, 50, 12'hFFF);
        vs_pulse(1'b0);
        pixel("coinc_new_visible", 300, 200, 12'hFFF);
        pixel("coinc_old_gone", 100, 50, 12'h9D5);

        // 64 frames: counter wraps, cursor blanked while bit 5 is set
        for (int i = 0; i < 64; i++) begin
            vs_pulse(1'b0);
            if (exp_fcnt == 6'd31) pixel("blink_on_31", 300, 200, 12'hFFF);
            if (exp_fcnt == 6'd32) pixel("blink_off_32", 300, 200, 12'h94F);
            if (exp_fcnt == 6'd63) pixel("blink_off_63", 300, 200, 12'h94F);
            if (exp_fcnt == 6'd0)  pixel("blink_on_0", 300, 200, 12'hFFF);
        end
        pixel("after_wrap", 300, 200, 12'hFFF);

        // Asynchronous reset mid-line
        x = 10'd10; y = 10'd10; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_rgb", 32'(rgb), 32'h40A);
        check("pre_rst_hsync", 32'(hsync), 32'd1);
        check("pre_rst_vsync", 32'(vsync), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rgb", 32'(rgb), 32'd0);
        check("async_hsync", 32'(hsync), 32'd0);
        check("async_vsync", 32'(vsync), 32'd0);
        check("async_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        vsync_in = 1'b0;
        reset_n  = 1'b1;

        tbl.delete();
        add(10, 10, 0, 1, 0, 0, 12'h000);
        add(10, 10, 0, 0, 1, 0, 12'h000);
        add(10, 10, 0, 1, 1, 0, 12'h000);
        add(10, 10, 0, 0, 0, 0, 12'h000);
        add(10, 10, 0, 1, 0, 0, 12'h000);
        add(10, 10, 0, 0, 1, 0, 12'h000);
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
